// File: rtl/fetch_phase_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the fetch phase.
package fetch_phase_pkg;
   localparam int unsigned PC_W   = 32;
   localparam int unsigned INST_W = 32;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_phase_if.sv
// Fetch-phase signal bundle: instruction-memory port, redirect input, decode output.
interface fetch_phase_if;
   import fetch_phase_pkg::*;

   logic              imem_en;
   logic [PC_W-1:0]   imem_addr;
   logic [INST_W-1:0] imem_data;
   logic              redirect_valid;
   logic [PC_W-1:0]   redirect_pc;
   logic              stall;
   logic [INST_W-1:0] inst;
   logic [PC_W-1:0]   inst_pc;
   logic              inst_valid;

   modport master (
      output imem_en, imem_addr, inst, inst_pc, inst_valid,
      input  imem_data, redirect_valid, redirect_pc, stall
   );

   modport slave (
      input  imem_en, imem_addr, inst, inst_pc, inst_valid,
      output imem_data, redirect_valid, redirect_pc, stall
   );
endinterface

// File: rtl/fetch_phase_inst_queue.sv
// Two-entry instruction queue with flush; head entry is presented combinationally from storage.
module inst_queue
   import fetch_phase_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);
   fetch_entry_t mem_q [2];
   logic         rd_ptr_q;
   logic         wr_ptr_q;
   logic [1:0]   count_q;
   logic         do_push;
   logic         do_pop;

   // Guards keep the queue from ever over- or underflowing.
   assign do_pop  = pop_i && (count_q != 2'd0);
   assign do_push = push_i && ((count_q < 2'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_q + 2'(do_push) - 2'(do_pop);
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
endmodule

// File: rtl/fetch_phase.sv
// Instruction fetch: sequential PC generation, 1-cycle imem read, 2-deep queue toward decode, redirect flush.
module fetch_phase
   import fetch_phase_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     PC_STEP  = 4,
   parameter int unsigned     DEPTH    = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_phase_if.master fp_io
);
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] req_pc_q;
   logic            inflight_q;
   logic            squash_q;
   fetch_state_e    state_q;

   logic [1:0]      count;
   logic [2:0]      occupancy;
   logic            deq;
   logic            enq;
   logic            issue;
   fetch_entry_t    enq_entry;
   fetch_entry_t    head;

   assign fp_io.inst_valid = (count != 2'd0);
   assign deq = fp_io.inst_valid && !fp_io.stall && !fp_io.redirect_valid;

   // Issue only if the returning word is guaranteed a free queue slot.
   assign occupancy = 3'(count) + 3'(inflight_q) - 3'(deq);
   assign issue     = !rst && !fp_io.redirect_valid && (occupancy < 3'(DEPTH));
   assign enq       = inflight_q && !squash_q;

   assign fp_io.imem_en   = issue;
   assign fp_io.imem_addr = pc_q;

   always_comb begin
      enq_entry      = '0;
      enq_entry.inst = fp_io.imem_data;
      enq_entry.pc   = req_pc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         squash_q   <= 1'b0;
         state_q    <= S_RUN;
      end else begin
         inflight_q <= issue;
         if (issue) begin
            pc_q     <= pc_q + PC_W'(PC_STEP);
            req_pc_q <= pc_q;
         end
         // Redirect wins in any state; S_FLUSH issues the target on the following cycle.
         if (fp_io.redirect_valid) begin
            pc_q     <= fp_io.redirect_pc;
            squash_q <= inflight_q;
            state_q  <= S_FLUSH;
         end else if (state_q == S_FLUSH) begin
            squash_q <= 1'b0;
            state_q  <= S_RUN;
         end
      end
   end

   inst_queue #(
      .DEPTH (DEPTH)
   ) u_inst_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (enq),
      .push_data_i (enq_entry),
      .pop_i       (deq),
      .flush_i     (fp_io.redirect_valid),
      .head_o      (head),
      .count_o     (count)
   );

   assign fp_io.inst    = head.inst;
   assign fp_io.inst_pc = head.pc;
endmodule

// File: tb/tb_fetch_phase.sv
// Bench for fetch_phase: directed vector table, wrap sequence, then random traffic against a stream model.
module tb_fetch_phase;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cyc;

   fetch_phase_if fpif ();

   fetch_phase #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (4),
      .DEPTH    (2)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .fp_io (fpif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   // Memory returns data one cycle after a request; junk otherwise.
   always @(posedge clk) fpif.imem_data <= fpif.imem_en ? mem_f(fpif.imem_addr) : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic st);
      @(posedge clk);
      #1;
      rst                 = r;
      fpif.redirect_valid = rv;
      fpif.redirect_pc    = rp;
      fpif.stall          = st;
      cyc++;
      @(negedge clk);
   endtask

   // Stream model: accepted PCs step by 4 from the latest target; fetch restarts the cycle after a
   // redirect (or the first cycle out of reset) and decode sees valid data two cycles after that.
   int          since;
   bit          pend;
   logic [31:0] exp_pc;
   logic [31:0] fetch_pc;

   task automatic model_check();
      bit exp_valid;
      if (rst) begin
         chk("rst_valid", 32'(fpif.inst_valid), 32'd0);
         chk("rst_en", 32'(fpif.imem_en), 32'd0);
         chk("rst_inst_pc", fpif.inst_pc, 32'd0);
         chk("rst_inst", fpif.inst, 32'd0);
         pend     = 1'b1;
         since    = -1000;
         exp_pc   = RESET_PC;
         fetch_pc = RESET_PC;
      end else begin
         if (pend) begin
            since = 0;
            pend  = 1'b0;
         end
         if (fpif.redirect_valid) chk("redir_en", 32'(fpif.imem_en), 32'd0);
         else if (since == 0) chk("restart_en", 32'(fpif.imem_en), 32'd1);
         if (fpif.imem_en) begin
            chk("imem_addr", fpif.imem_addr, fetch_pc);
            fetch_pc = fetch_pc + 32'd4;
         end
         exp_valid = (since >= 2);
         chk("inst_valid", 32'(fpif.inst_valid), 32'(exp_valid));
         if (exp_valid) begin
            chk("inst_pc", fpif.inst_pc, exp_pc);
            chk("inst", fpif.inst, mem_f(exp_pc));
         end
         if (fpif.redirect_valid) begin
            exp_pc   = fpif.redirect_pc;
            fetch_pc = fpif.redirect_pc;
            pend     = 1'b1;
            since    = -1000;
         end else begin
            if (exp_valid && !fpif.stall) exp_pc = exp_pc + 32'd4;
            since++;
         end
      end
   endtask

   typedef struct {
      logic        r;
      logic        rv;
      logic [31:0] rp;
      logic        st;
      logic        ev;
      logic [31:0] epc;
      logic        een;
      logic [31:0] eaddr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic r, input logic rv, input logic [31:0] rp, input logic st,
                              input logic ev, input logic [31:0] epc, input logic een,
                              input logic [31:0] eaddr);
      vec_t x;
      x.r = r; x.rv = rv; x.rp = rp; x.st = st;
      x.ev = ev; x.epc = epc; x.een = een; x.eaddr = eaddr;
      return x;
   endfunction

   logic        r_r, r_rv, r_st;
   logic [31:0] r_tgt;

   initial begin
      total = 0; bad = 0; cyc = 0;
      rst = 1'b1;
      fpif.redirect_valid = 1'b0;
      fpif.redirect_pc    = '0;
      fpif.stall          = 1'b0;

      // reset, stream, stall while presenting 8
      vecs.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h4));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h0, 1, 32'h8));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h4, 1, 32'hC));
      for (int i = 0; i < 5; i++) vecs.push_back(v(0, 0, 0, 1, 1, 32'h8, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h8, 1, 32'h10));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'hC, 1, 32'h14));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h10, 1, 32'h18));
      // redirect with a read inflight
      vecs.push_back(v(0, 1, 32'h100, 0, 1, 32'h14, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h100));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h104));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h100, 1, 32'h108));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h104, 1, 32'h10C));
      // redirect together with stall
      vecs.push_back(v(0, 1, 32'h200, 1, 1, 32'h108, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 1, 32'h200));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 1, 32'h204));
      vecs.push_back(v(0, 0, 0, 1, 1, 32'h200, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h200, 1, 32'h208));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h204, 1, 32'h20C));
      // back-to-back redirects
      vecs.push_back(v(0, 1, 32'h300, 0, 1, 32'h208, 0, 0));
      vecs.push_back(v(0, 1, 32'h400, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h400));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h404));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h400, 1, 32'h408));
      // fill the queue, then reset mid-operation
      vecs.push_back(v(0, 0, 0, 1, 1, 32'h404, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 32'h404, 0, 0));
      vecs.push_back(v(1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h0));
      vecs.push_back(v(0, 0, 0, 0, 0, 0, 1, 32'h4));
      vecs.push_back(v(0, 0, 0, 0, 1, 32'h0, 1, 32'h8));

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].rv, vecs[i].rp, vecs[i].st);
         chk("vec_valid", 32'(fpif.inst_valid), 32'(vecs[i].ev));
         chk("vec_en", 32'(fpif.imem_en), 32'(vecs[i].een));
         if (vecs[i].een) chk("vec_addr", fpif.imem_addr, vecs[i].eaddr);
         if (vecs[i].ev) begin
            chk("vec_inst_pc", fpif.inst_pc, vecs[i].epc);
            chk("vec_inst", fpif.inst, mem_f(vecs[i].epc));
         end
         if (vecs[i].r) begin
            chk("vec_rst_inst_pc", fpif.inst_pc, 32'd0);
            chk("vec_rst_inst", fpif.inst, 32'd0);
         end
      end

      // Model-checked phase starts from a fresh reset.
      step(1, 0, 0, 0); model_check();
      for (int i = 0; i < 4; i++) begin step(0, 0, 0, 0); model_check(); end

      // PC wrap across 32'hFFFF_FFFC
      step(0, 1, 32'hFFFF_FFF8, 0); model_check();
      for (int k = 1; k <= 5; k++) begin
         step(0, 0, 0, 0); model_check();
         if (k == 3) begin
            chk("wrap_en", 32'(fpif.imem_en), 32'd1);
            chk("wrap_addr", fpif.imem_addr, 32'h0000_0000);
         end
         if (k == 5) chk("wrap_inst_pc", fpif.inst_pc, 32'h0000_0000);
      end

      for (int n = 0; n < 3000; n++) begin
         r_r   = ($urandom_range(0, 299) == 0);
         r_rv  = ($urandom_range(0, 11) == 0);
         r_st  = ($urandom_range(0, 9) < 4);
         r_tgt = $urandom;
         if ($urandom_range(0, 3) == 0) r_tgt = 32'hFFFF_FFE0 | (r_tgt & 32'h0000_001F);
         r_tgt[1:0] = 2'b00;
         step(r_r, r_rv, r_tgt, r_st);
         model_check();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
